// File: rtl/lut_interp_reader.sv
// lut_interp_reader: two-stage pipelined LUT linear interpolator with valid/ready handshakes
module lut_interp_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic [ADDR_W-1:0]        lut_address,
  input  logic signed [DATA_W-1:0] lut_base,
  input  logic signed [DATA_W-1:0] lut_next,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [15:0]              out_count
);
  localparam int FRAC_W = DATA_W - ADDR_W;
  localparam int PW = DATA_W + FRAC_W + 1;
  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_base, s1_next;
  logic [FRAC_W-1:0]        s1_frac;
  logic                     s2_load, adv, in_fire, out_fire;
  logic signed [DATA_W:0]   diff;
  logic signed [PW-1:0]     prod;
  logic signed [DATA_W-1:0] res;
  assign lut_address = in_data[DATA_W-1:FRAC_W];
  assign s2_load = !out_valid || out_ready;
  assign adv = s1_valid && s2_load;
  assign in_ready = !s1_valid || s2_load;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign diff = {s1_next[DATA_W-1], s1_next} - {s1_base[DATA_W-1], s1_base};
  assign prod = {{(PW-DATA_W-1){diff[DATA_W]}}, diff} * {{(PW-FRAC_W){1'b0}}, s1_frac};
  assign res = DATA_W'($signed({{(PW-DATA_W){s1_base[DATA_W-1]}}, s1_base}) + (prod >>> FRAC_W));
  // Stage 1: capture LUT pair and fraction on each accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_base  <= '0;
      s1_next  <= '0;
      s1_frac  <= '0;
    end else begin
      s1_valid <= in_fire ? 1'b1 : (adv ? 1'b0 : s1_valid);
      if (in_fire) begin
        s1_base <= lut_base;
        s1_next <= lut_next;
        s1_frac <= in_data[FRAC_W-1:0];
      end
    end
  end
  // Stage 2: register the interpolated result whenever the output slot is free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (adv) out_data <= res;
    end
  end
  // Completed output transfer counter, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_count <= '0;
    else if (out_fire) out_count <= out_count + 16'd1;
  end
endmodule

// File: doc/lut_interp_reader.md
LUT_INTERP_READER -- requirements
Module: lut_interp_reader

Interface
REQ-001 Parameter DATA_W, 8: width of the signed input sample, the LUT entries and the result.
REQ-002 Parameter ADDR_W, 4: LUT address width; FRAC_W = DATA_W - ADDR_W (4) is derived, not a parameter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  upstream sample valid.
REQ-006 in_ready  out  1  block accepts a sample this cycle.
REQ-007 in_data  in  DATA_W  signed sample: upper ADDR_W bits are the segment, lower FRAC_W bits are the fraction.
REQ-008 lut_address  out  ADDR_W  combinational, always equal to in_data[DATA_W-1:FRAC_W].
REQ-009 lut_base  in  DATA_W signed  combinational LUT entry at lut_address.
REQ-010 lut_next  in  DATA_W signed  combinational next LUT entry; the LUT itself resolves the end-of-table cases.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  downstream accepts the result.
REQ-013 out_data  out  DATA_W signed  interpolated activation value.
REQ-014 out_count  out  16  number of completed output transfers, modulo 2^16.

Function
REQ-015 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-016 Stage 1 SHALL capture lut_base, lut_next and the fraction (in_data[FRAC_W-1:0]) on an input transfer and set s1_valid.
REQ-017 Stage 2 SHALL compute the result from the stage-1 registers, register it into out_data, and set out_valid.
REQ-018 Arithmetic: diff = lut_next - lut_base (DATA_W+1 bits, signed).
REQ-019 Arithmetic: prod = diff * frac, with frac zero-extended to unsigned (DATA_W+FRAC_W+1 bits).
REQ-020 Arithmetic: result = lut_base + (prod >>> FRAC_W), using an arithmetic shift (floor); out_data SHALL be the low DATA_W bits.
REQ-021 The result always lies between lut_base and lut_next inclusive, so the truncation in REQ-020 is exact; no saturation logic SHALL be added.
REQ-022 Stage-2 load condition: s2_load = !out_valid || out_ready.
REQ-023 Stage 1 SHALL advance into stage 2 when s1_valid && s2_load.
REQ-024 in_ready SHALL equal !s1_valid || s2_load (combinational); in_ready depends on out_ready but never on in_valid.
REQ-025 Latency: a sample accepted at edge N SHALL have out_valid=1 after edge N+1 if there is no backpressure.
REQ-026 Throughput SHALL be one sample per cycle while out_ready=1.
REQ-027 Under backpressure, stage 1 and stage 2 SHALL each hold one sample, so the block buffers at most 2 samples.
REQ-028 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 A stage-2 drain and a stage-1 refill in the same cycle SHALL lose no sample and duplicate no sample.
REQ-030 s1_valid SHALL clear when stage 1 advances and no new input transfer occurs in the same cycle.
REQ-031 out_valid SHALL clear on an output transfer when s1_valid=0.
REQ-032 out_count SHALL increment by 1 on each output transfer and wrap from 0xFFFF to 0x0000.

Reset
REQ-033 While rst=1: s1_valid=0, out_valid=0, out_data=0, out_count=0, and all stage-1 registers=0, asynchronously.
REQ-034 While rst=1, in_ready SHALL be 1 (it follows from REQ-024), but no transfer SHALL be recorded.
REQ-035 Reset asserted mid-operation SHALL discard all buffered samples.
REQ-036 After rst deasserts, the first rising edge SHALL operate normally.

Verification
All scenarios use a LUT model with lut[0..7] = 0,16,...,112 and lut[8..15] = 0. The model returns next = lut[a+1], except next = lut[7] at a=7 and next = lut[0] at a=15.
REQ-037 in_data=0x25, out_ready=1 -> lut_address=2; two cycles later out_data=37 (32+(16*5>>4)) and out_count=1.
REQ-038 in_data=0x7F -> out_data=112; in_data=0xF8 -> out_data=0; in_data=0x00 -> out_data=0.
REQ-039 in_data=0x18 -> out_data=24. Then force lut_base=112 and lut_next=-128 with frac=15 -> out_data=-113 (floor of -225), checking the negative-diff case.
REQ-040 Hold out_ready=0 and present 3 samples back-to-back -> 2 accepted, in_ready=0 on the third, out_data stable.
REQ-041 Release out_ready in REQ-040 -> all 3 outputs emerge in order, each exactly once, with no gap cycles.
REQ-042 Assert rst with 2 samples buffered -> out_valid=0 and out_count=0 immediately; the first post-reset sample emerges with correct value and out_count=1.
REQ-043 Preload out_count to 0xFFFF with 65535 transfers -> one more transfer gives out_count=0x0000.
REQ-044 Random in_valid/out_ready over 10k samples -> outputs match the reference model in order and out_count equals the transfer total mod 2^16.
